servo_pwm_capture: RTL

SERVO_PWM_CAPTURE -- requirements
Module: servo_pwm_capture

---
 rtl/servo_pwm_capture.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/servo_pwm_capture.sv
// RC-servo PWM capture: measures high time and rising-to-rising period in whole microseconds.
// Optional glitch filter on the synchronized input is enabled by defining SERVO_CAPTURE_GLITCH_FILTER_EN.
module servo_pwm_capture #(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 25000,
  parameter int FILTER_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  input  logic        enable,
  output logic [15:0] width_us,
  output logic [15:0] period_us,
  output logic        sample_valid,
  output logic        signal_lost
);

  localparam int TICK_DIV = CLK_HZ / 1000000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_US - 1);
  // Cycles after reset before lvl reflects pwm_in; covers the longest input pipeline.
  localparam int SETTLE = 2 + FILTER_LEN;
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t           state, state_nx;
  logic             sync_meta, sync_lvl, lvl, lvl_d;
  logic             rise, fall, tick, to_hit, rise_acc, fall_acc, edge_acc;
  logic             take_sample, latch_width, lose, settled;
  logic [PRE_W-1:0] pre;
  logic [SET_W-1:0] settle_cnt;
  logic [15:0]      high_cnt, period_cnt, timeout_cnt, width_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= pwm_in;
      sync_lvl  <= sync_meta;
    end
  end

`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_lvl;

  // lvl follows sync_lvl only once the new value has held FILTER_LEN cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b0;
    end else if (sync_lvl == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_LAST) begin
      flt_cnt <= '0;
      flt_lvl <= sync_lvl;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
  assign lvl = flt_lvl;
`else
  assign lvl = sync_lvl;
`endif

  assign rise     = lvl & ~lvl_d;
  assign fall     = ~lvl & lvl_d;
  assign tick     = (pre == PRE_LAST);
  assign to_hit   = tick && (timeout_cnt == TO_LAST);
  assign rise_acc = enable && rise && (state == WAIT_RISE || state == MEAS_LOW);
  assign fall_acc = enable && fall && (state == MEAS_HIGH);
  assign edge_acc = rise_acc | fall_acc;
  assign settled  = (settle_cnt == SET_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_LOW;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = WAIT_LOW;
    end else begin
      case (state)
        WAIT_LOW:  if (!lvl && settled) state_nx = WAIT_RISE;
        WAIT_RISE: if (rise) state_nx = MEAS_HIGH;
                   else if (to_hit) state_nx = WAIT_LOW;
        MEAS_HIGH: if (fall) state_nx = MEAS_LOW;
                   else if (to_hit) state_nx = WAIT_LOW;
        MEAS_LOW:  if (rise) state_nx = MEAS_HIGH;
                   else if (to_hit) state_nx = WAIT_LOW;
        default:   state_nx = WAIT_LOW;
      endcase
    end
  end

  // An accepted edge in the same cycle as the timeout wins.
  always_comb begin
    take_sample = 1'b0;
    latch_width = 1'b0;
    lose        = 1'b0;
    if (enable) begin
      take_sample = rise_acc && (state == MEAS_LOW);
      latch_width = fall_acc;
      lose        = to_hit && !edge_acc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_d        <= 1'b0;
      settle_cnt   <= '0;
      pre          <= '0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      timeout_cnt  <= '0;
      width_hold   <= '0;
      width_us     <= '0;
      period_us    <= '0;
      sample_valid <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      lvl_d        <= lvl;
      sample_valid <= take_sample;
      if (!settled) settle_cnt <= settle_cnt + 1'b1;

      // The tick landing on the closing edge still counts, so whole microseconds are kept.
      if (take_sample) begin
        width_us    <= width_hold;
        period_us   <= period_cnt + {15'd0, tick};
        signal_lost <= 1'b0;
      end else if (lose) begin
        signal_lost <= 1'b1;
      end
      if (latch_width) width_hold <= high_cnt + {15'd0, tick};

      if (!enable || rise_acc || tick) pre <= '0;
      else                             pre <= pre + 1'b1;

      if (!enable || rise_acc) begin
        high_cnt   <= '0;
        period_cnt <= '0;
      end else if (tick) begin
        if (state == MEAS_HIGH) high_cnt <= high_cnt + 1'b1;
        if (state == MEAS_HIGH || state == MEAS_LOW) period_cnt <= period_cnt + 1'b1;
      end

      if (!enable || edge_acc || lose) timeout_cnt <= '0;
      else if (tick)                   timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule
